// File: rtl/fifo_drain_pkg.sv
// -----------------------------------------------------------------------------
// fifo_drain_pkg
// Shared definitions for the FIFO read-side drain controller.
//   drain_state_e : controller state encoding (IDLE / RUN / FULL)
//   SKID_DEPTH    : number of skid-buffer entries; the credit logic assumes 2
// Optional feature macro used by the block: FIFO_DRAIN_CNT_EN (delivered-word
// counter in fifo_drain_ctrl).
// -----------------------------------------------------------------------------
package fifo_drain_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } drain_state_e;

endpackage

// File: rtl/drain_skid_buf.sv
// -----------------------------------------------------------------------------
// drain_skid_buf
// Two-entry FIFO that absorbs the word still in flight from the upstream FIFO
// when the downstream stage stalls.
// Ports:
//   clk     in   clock, posedge
//   reset   in   asynchronous active-low reset, clears contents and pointers
//   wr_i    in   write strobe, data_i captured this edge
//   rd_i    in   read (dequeue) strobe, advances the head
//   data_i  in   write data
//   data_o  out  head entry (oldest word)
//   occ_o   out  number of valid entries (0..2)
// A write while full is dropped unless a read happens on the same edge.
// -----------------------------------------------------------------------------
module drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int BUS_SIZE = 5,
  parameter int DEPTH    = SKID_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_i,
  input  logic                rd_i,
  input  logic [BUS_SIZE-1:0] data_i,
  output logic [BUS_SIZE-1:0] data_o,
  output logic [1:0]          occ_o
);

  logic [BUS_SIZE-1:0] mem_q [DEPTH];
  logic                head_q, head_d;
  logic [1:0]          occ_q, occ_d;
  logic                rd_ok, wr_ok, tail;

  always_comb begin
    rd_ok  = rd_i && (occ_q != 2'd0);
    // When full, a write is only legal if the head slot is freed the same edge.
    wr_ok  = wr_i && ((occ_q != 2'd2) || rd_ok);
    // Tail = head + occupancy (mod 2); with occ=2 it lands on the slot being read.
    tail   = head_q ^ occ_q[0];
    head_d = head_q ^ rd_ok;
    occ_d  = occ_q;
    case ({wr_ok, rd_ok})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= 1'b0;
      occ_q  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      occ_q  <= occ_d;
      if (wr_ok) begin
        mem_q[tail] <= data_i;
      end
    end
  end

  assign data_o = mem_q[head_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_drain_ctrl
// Read-side controller for the synchronous FIFO. Pops while credit allows,
// captures the FIFO's 1-cycle-latency read data into a 2-entry skid buffer and
// forwards words downstream over valid/ready without loss under backpressure.
// Ports:
//   clk         in   clock, posedge
//   reset       in   asynchronous active-low reset; discards buffered words
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out
//   fifo_valid  in   FIFO valid_out (cycle after an accepted pop)
//   pop         out  read strobe to the FIFO
//   out_data    out  downstream data (skid head)
//   out_valid   out  downstream valid
//   out_ready   in   downstream ready
//   busy        out  high while a word is in flight or buffered
//   word_count  out  delivered-word count, wraps (only with FIFO_DRAIN_CNT_EN)
// Optional feature: define FIFO_DRAIN_CNT_EN to add the word_count port and
// counter (parameter CNT_WIDTH).
// -----------------------------------------------------------------------------
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int BUS_SIZE   = 5,
  parameter int SKID_DEPTH = fifo_drain_pkg::SKID_DEPTH
`ifdef FIFO_DRAIN_CNT_EN
  ,
  parameter int CNT_WIDTH  = 8
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [BUS_SIZE-1:0]  fifo_data,
  input  logic                 fifo_valid,
  output logic                 pop,
  output logic [BUS_SIZE-1:0]  out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] word_count
`endif
);

  drain_state_e state_q, state_d;
  logic         inflight_q;
  logic [1:0]   occ;
  logic         deq;
  logic         skid_wr;
  logic [2:0]   credit_use;

  drain_skid_buf #(
    .BUS_SIZE (BUS_SIZE),
    .DEPTH    (SKID_DEPTH)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (skid_wr),
    .rd_i   (deq),
    .data_i (fifo_data),
    .data_o (out_data),
    .occ_o  (occ)
  );

  assign out_valid = (occ != 2'd0);
  assign deq       = out_valid & out_ready;
  // Only data answering one of our own pops is accepted; stray valids are dropped.
  assign skid_wr   = fifo_valid & inflight_q;
  // Entries committed after this edge: buffered + in flight - leaving now.
  // deq implies occ>0, so this never underflows.
  assign credit_use = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deq};
  // Gated by reset so no read strobe reaches the FIFO while we are held in reset.
  assign pop = reset && !fifo_empty && (credit_use < 3'd2);
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop) state_d = RUN;
      end
      RUN: begin
        if (occ == 2'd2) begin
          state_d = FULL;
        end else if ((occ == 2'd0) && !inflight_q && fifo_empty) begin
          state_d = IDLE;
        end
      end
      FULL: begin
        if (deq) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= pop;
    end
  end

`ifdef FIFO_DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] word_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_count_q <= '0;
    end else if (deq) begin
      word_count_q <= word_count_q + 1'b1;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule
